// File: rtl/reg_file_xfer.sv
// rtl/reg_file_xfer.sv - scalar register file plus wide bitmap registers with a chunked stream transfer engine
module reg_file_xfer #(
    parameter int N_REGS  = 16,
    parameter int W       = 16,
    parameter int N_BM    = 3,
    parameter int BW      = 1536,
    parameter int CW      = 16,
    parameter int ZERO_R0 = 0,
    localparam int AW     = (N_REGS > 1) ? $clog2(N_REGS) : 1,
    localparam int BAW    = (N_BM > 1) ? $clog2(N_BM) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [AW-1:0]  rd_addr_1,
    output logic [W-1:0]   rd_data_1,
    input  logic [AW-1:0]  rd_addr_2,
    output logic [W-1:0]   rd_data_2,
    input  logic [AW-1:0]  wr_addr,
    input  logic [W-1:0]   wr_data,
    input  logic           wr,
    input  logic [BAW-1:0] rbm_addr,
    output logic [BW-1:0]  rbm_data,
    input  logic [BAW-1:0] wbm_addr,
    input  logic [BW-1:0]  wbm_data,
    input  logic           wbm,
    input  logic           xfer_start,
    input  logic           xfer_dir,
    input  logic [BAW-1:0] xfer_addr,
    output logic           xfer_busy,
    output logic           xfer_done,
    input  logic           ld_valid,
    input  logic [CW-1:0]  ld_data,
    output logic           ld_ready,
    output logic           st_valid,
    output logic [CW-1:0]  st_data,
    input  logic           st_ready
);

    localparam int BEATS = BW / CW;
    localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BIW   = (BW > 1) ? $clog2(BW) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nx;

    logic [W-1:0]   regs [N_REGS];
    logic [BW-1:0]  bm   [N_BM];

    logic [BAW-1:0] tgt;
    logic [KW-1:0]  k;
    logic           done_q;
    logic [BIW-1:0] base;

    logic           wr_ok;
    logic           start_ok;
    logic           ld_fire;
    logic           st_fire;
    logic           last_beat;

    // A scalar address is usable when it exists and is not the hardwired-zero r0.
    function automatic logic reg_ok(input logic [AW-1:0] a);
        return (int'(a) < N_REGS) && !((ZERO_R0 != 0) && (a == '0));
    endfunction

    assign wr_ok     = wr && reg_ok(wr_addr);
    assign start_ok  = (state == IDLE) && xfer_start && (int'(xfer_addr) < N_BM);
    assign ld_fire   = ld_valid && ld_ready;
    assign st_fire   = st_valid && st_ready;
    assign last_beat = (k == KW'(BEATS - 1));
    assign base      = BIW'(k) * BIW'(CW);
    assign xfer_done = done_q;

    // Scalar register storage; dropped writes never touch the array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Read port 1 with same-cycle forwarding of the pending write.
    always_comb begin
        rd_data_1 = '0;
        if (reg_ok(rd_addr_1)) begin
            if (wr_ok && (wr_addr == rd_addr_1)) begin
                rd_data_1 = wr_data;
            end else begin
                rd_data_1 = regs[rd_addr_1];
            end
        end
    end

    // Read port 2 with same-cycle forwarding of the pending write.
    always_comb begin
        rd_data_2 = '0;
        if (reg_ok(rd_addr_2)) begin
            if (wr_ok && (wr_addr == rd_addr_2)) begin
                rd_data_2 = wr_data;
            end else begin
                rd_data_2 = regs[rd_addr_2];
            end
        end
    end

    // Bitmap storage: load beats land in the target chunk; full-width writes skip the busy target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_BM; i++) begin
                bm[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BM; i++) begin
                if (ld_fire && (tgt == BAW'(i))) begin
                    bm[i][base +: CW] <= ld_data;
                end else if (wbm && (wbm_addr == BAW'(i)) && !(xfer_busy && (tgt == BAW'(i)))) begin
                    bm[i] <= wbm_data;
                end
            end
        end
    end

    // Full-width bitmap read, zero for addresses past the last register.
    always_comb begin
        rbm_data = '0;
        if (int'(rbm_addr) < N_BM) begin
            rbm_data = bm[rbm_addr];
        end
    end

    // Transfer FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Transfer FSM next state: leave IDLE on a valid start, return after the final beat.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start_ok) state_nx = xfer_dir ? STORE : LOAD;
            LOAD:    if (ld_fire && last_beat) state_nx = IDLE;
            STORE:   if (st_fire && last_beat) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Transfer FSM outputs: handshakes and the store chunk selected by the beat counter.
    always_comb begin
        xfer_busy = (state != IDLE);
        ld_ready  = (state == LOAD);
        st_valid  = (state == STORE);
        st_data   = '0;
        if (state == STORE) begin
            st_data = bm[tgt][base +: CW];
        end
    end

    // Target latch, beat counter and the one-cycle completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt    <= '0;
            k      <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (ld_fire || st_fire) && last_beat;
            if (start_ok) begin
                tgt <= xfer_addr;
                k   <= '0;
            end else if (ld_fire || st_fire) begin
                k <= last_beat ? '0 : k + KW'(1);
            end
        end
    end

endmodule

// File: tb/tb_reg_file_xfer.sv
// tb/tb_reg_file_xfer.sv - randomized self-checking bench for reg_file_xfer against a behavioural model
module tb_reg_file_xfer;

    localparam int N_REGS = 16;
    localparam int W      = 16;
    localparam int N_BM   = 3;
    localparam int BW     = 1536;
    localparam int CW     = 16;
    localparam int BEATS  = BW / CW;
    localparam int AW     = 4;
    localparam int BAW    = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [AW-1:0]  rd_addr_1, rd_addr_2, wr_addr;
    logic [W-1:0]   wr_data;
    logic           wr;
    logic [BAW-1:0] rbm_addr, wbm_addr, xfer_addr;
    logic [BW-1:0]  wbm_data;
    logic           wbm, xfer_start, xfer_dir, ld_valid, st_ready;
    logic [CW-1:0]  ld_data;

    logic [W-1:0]   rd_data_1, rd_data_2, z_rd_data_1, z_rd_data_2;
    logic [BW-1:0]  rbm_data, z_rbm_data;
    logic           xfer_busy, xfer_done, ld_ready, st_valid;
    logic           z_busy, z_done, z_ld_ready, z_st_valid;
    logic [CW-1:0]  st_data, z_st_data;

    logic [W-1:0]   m_reg  [N_REGS];
    logic [W-1:0]   mz_reg [N_REGS];
    logic [BW-1:0]  m_bm   [N_BM];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    reg_file_xfer #(.ZERO_R0(0)) dut (
        .clk(clk), .rst(rst),
        .rd_addr_1(rd_addr_1), .rd_data_1(rd_data_1),
        .rd_addr_2(rd_addr_2), .rd_data_2(rd_data_2),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr(wr),
        .rbm_addr(rbm_addr), .rbm_data(rbm_data),
        .wbm_addr(wbm_addr), .wbm_data(wbm_data), .wbm(wbm),
        .xfer_start(xfer_start), .xfer_dir(xfer_dir), .xfer_addr(xfer_addr),
        .xfer_busy(xfer_busy), .xfer_done(xfer_done),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .st_valid(st_valid), .st_data(st_data), .st_ready(st_ready)
    );

    reg_file_xfer #(.ZERO_R0(1)) dut_z (
        .clk(clk), .rst(rst),
        .rd_addr_1(rd_addr_1), .rd_data_1(z_rd_data_1),
        .rd_addr_2(rd_addr_2), .rd_data_2(z_rd_data_2),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr(wr),
        .rbm_addr(rbm_addr), .rbm_data(z_rbm_data),
        .wbm_addr(wbm_addr), .wbm_data(wbm_data), .wbm(wbm),
        .xfer_start(xfer_start), .xfer_dir(xfer_dir), .xfer_addr(xfer_addr),
        .xfer_busy(z_busy), .xfer_done(z_done),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(z_ld_ready),
        .st_valid(z_st_valid), .st_data(z_st_data), .st_ready(st_ready)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BW-1:0] rand_bm();
        logic [BW-1:0] v;
        for (int i = 0; i < BW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N_REGS; i++) begin
            m_reg[i]  = '0;
            mz_reg[i] = '0;
        end
        for (int i = 0; i < N_BM; i++) m_bm[i] = '0;
    endtask

    task automatic drive_idle();
        wr = 0; wr_addr = 0; wr_data = 0; rd_addr_1 = 0; rd_addr_2 = 0;
        rbm_addr = 0; wbm_addr = 0; wbm_data = '0; wbm = 0;
        xfer_start = 0; xfer_dir = 0; xfer_addr = 0;
        ld_valid = 0; ld_data = 0; st_ready = 0;
    endtask

    // Expected scalar read: r0 is zero on the ZERO_R0 copy, a pending write forwards.
    function automatic logic [W-1:0] exp_rd(input int ra, input bit z);
        if (z && ra == 0) return '0;
        if (wr && int'(wr_addr) == ra && !(z && wr_addr == 0)) return wr_data;
        return z ? mz_reg[ra] : m_reg[ra];
    endfunction

    task automatic scalar_cycle(input string tag);
        #1;
        check_val({tag, "_rd1"},   64'(rd_data_1),   64'(exp_rd(int'(rd_addr_1), 1'b0)));
        check_val({tag, "_rd2"},   64'(rd_data_2),   64'(exp_rd(int'(rd_addr_2), 1'b0)));
        check_val({tag, "_z_rd1"}, 64'(z_rd_data_1), 64'(exp_rd(int'(rd_addr_1), 1'b1)));
        check_val({tag, "_z_rd2"}, 64'(z_rd_data_2), 64'(exp_rd(int'(rd_addr_2), 1'b1)));
        if (wr) begin
            m_reg[wr_addr] = wr_data;
            if (wr_addr != 0) mz_reg[wr_addr] = wr_data;
        end
        step();
        wr = 0;
    endtask

    task automatic check_bm(input string tag);
        logic [63:0] e;
        for (int a = 0; a < 4; a++) begin
            rbm_addr = BAW'(a);
            #1;
            for (int s = 0; s < BW / 64; s++) begin
                e = (a < N_BM) ? m_bm[a][s*64 +: 64] : 64'd0;
                check_val($sformatf("%s_bm%0d_s%0d", tag, a, s), rbm_data[s*64 +: 64], e);
            end
        end
    endtask

    // mode 0: continuous handshake, 1: toggling, 2: random. abort_at >= 0 resets mid-load.
    task automatic run_xfer(input bit dir, input int addr, input int mode, input bit poke, input int abort_at);
        int k;
        int cyc;
        int other;
        bit go;
        logic [CW-1:0] d;
        logic [BW-1:0] v;
        k = 0;
        other = (addr + 2) % N_BM;
        xfer_start = 1; xfer_dir = dir; xfer_addr = BAW'(addr);
        step();
        xfer_start = 0;
        cyc = 1;
        while (k < BEATS) begin
            if (cyc > 4000) begin
                check_val("xfer_timeout", 64'(k), 64'(BEATS));
                break;
            end
            if (abort_at >= 0 && k == abort_at) begin
                #2;
                rst = 1;
                #1;
                model_clear();
                check_val("abort_busy",  64'(xfer_busy), 64'd0);
                check_val("abort_ready", 64'(ld_ready),  64'd0);
                check_val("abort_done",  64'(xfer_done), 64'd0);
                rd_addr_1 = 4'd5;
                #1;
                check_val("abort_rd1", 64'(rd_data_1), 64'd0);
                check_bm("abort");
                drive_idle();
                step();
                rst = 0;
                return;
            end
            go = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
            d  = (mode == 0) ? CW'(k) : CW'($urandom);
            wbm = 0;
            xfer_start = 0;
            if (!dir) begin
                ld_valid = go; ld_data = d; st_ready = 1'($urandom);
            end else begin
                st_ready = go; ld_valid = 1'($urandom); ld_data = CW'($urandom);
            end
            if (poke && cyc == 10) begin
                wbm = 1; wbm_addr = BAW'(addr); wbm_data = rand_bm();
            end
            if (poke && cyc == 20) begin
                v = rand_bm();
                wbm = 1; wbm_addr = BAW'(other); wbm_data = v;
                m_bm[other] = v;
            end
            if (poke && cyc == 30) begin
                xfer_start = 1; xfer_dir = ~dir; xfer_addr = BAW'(other);
            end
            #1;
            check_val("run_busy",  64'(xfer_busy), 64'd1);
            check_val("run_done",  64'(xfer_done), 64'd0);
            check_val("run_ready", 64'(ld_ready),  64'(!dir));
            check_val("run_valid", 64'(st_valid),  64'(dir));
            if (dir) check_val($sformatf("st_data_k%0d", k), 64'(st_data), 64'(m_bm[addr][k*CW +: CW]));
            if (go) begin
                if (!dir) m_bm[addr][k*CW +: CW] = d;
                k++;
            end
            step();
            cyc++;
        end
        ld_valid = 0; st_ready = 0; wbm = 0; xfer_start = 0;
        #1;
        check_val("end_done",  64'(xfer_done), 64'd1);
        check_val("end_busy",  64'(xfer_busy), 64'd0);
        check_val("end_ready", 64'(ld_ready),  64'd0);
        check_val("end_valid", 64'(st_valid),  64'd0);
        if (mode == 0) check_val("latency", 64'(cyc), 64'(BEATS + 1));
        step();
        check_val("done_pulse", 64'(xfer_done), 64'd0);
    endtask

    initial begin
        logic [BW-1:0] v;
        rst = 1;
        drive_idle();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_busy",   64'(xfer_busy), 64'd0);
        check_val("rst_done",   64'(xfer_done), 64'd0);
        check_val("rst_ready",  64'(ld_ready),  64'd0);
        check_val("rst_valid",  64'(st_valid),  64'd0);
        check_val("rst_stdata", 64'(st_data),   64'd0);
        check_val("rst_rd1",    64'(rd_data_1), 64'd0);
        check_val("rst_rd2",    64'(rd_data_2), 64'd0);
        check_bm("rst");
        step();
        rst = 0;

        wr = 1; wr_addr = 4'd5; wr_data = 16'hBEEF; rd_addr_1 = 4'd5; rd_addr_2 = 4'd5;
        scalar_cycle("fwd");
        rd_addr_1 = 4'd6;
        scalar_cycle("after_wr");

        wr = 1; wr_addr = 4'd0; wr_data = 16'h1234; rd_addr_1 = 4'd0; rd_addr_2 = 4'd15;
        scalar_cycle("r0_wr");
        wr = 1; wr_addr = 4'd15; wr_data = 16'h5A5A;
        scalar_cycle("r15_wr");
        scalar_cycle("r15_rd");

        repeat (150) begin
            wr = 1'($urandom); wr_addr = AW'($urandom); wr_data = W'($urandom);
            rd_addr_1 = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom);
            rd_addr_2 = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom);
            scalar_cycle("rand");
        end

        run_xfer(1'b0, 1, 0, 1'b0, -1);
        check_bm("load1");

        v = rand_bm();
        wbm = 1; wbm_addr = 2'd2; wbm_data = v; m_bm[2] = v;
        step();
        wbm = 0;
        run_xfer(1'b1, 2, 1, 1'b0, -1);
        check_bm("store2");

        run_xfer(1'b0, 0, 2, 1'b1, -1);
        check_bm("poke0");

        xfer_start = 1; xfer_dir = 0; xfer_addr = 2'd3;
        step();
        xfer_start = 0;
        check_val("bad_start_busy", 64'(xfer_busy), 64'd0);
        step();
        check_val("bad_start_done", 64'(xfer_done), 64'd0);

        run_xfer(1'b0, 1, 0, 1'b0, 40);
        run_xfer(1'b0, 1, 0, 1'b0, -1);
        check_bm("after_abort");

        repeat (4) begin
            run_xfer(1'($urandom), int'($urandom_range(0, N_BM - 1)), 2, 1'($urandom), -1);
        end
        check_bm("random");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
